// File: rtl/pla_out_toggle_monitor.sv
// Windowed per-bit toggle counter on the registered PLA output vector (v27.0..v27.5).
// Define PLA_TOG_HAMMING_EN to add rpt_ham, the saturating total of toggled bits per window.
module pla_out_toggle_monitor #(
    parameter int unsigned OUT_W   = 6,
    parameter int unsigned WIN_LEN = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [OUT_W-1:0]       in_data,
    output logic                   in_ready,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [OUT_W*CNT_W-1:0] rpt_cnt,
    output logic [7:0]             rpt_win_id
`ifdef PLA_TOG_HAMMING_EN
    ,
    output logic [CNT_W+2:0]       rpt_ham
`endif
);

    localparam int unsigned SMP_W = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {
        S_PRIME  = 2'd0,
        S_ACCUM  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_W-1:0]       prev_q;
    logic [OUT_W-1:0]       tog;
    logic [SMP_W-1:0]       smp_q;
    logic [CNT_W-1:0]       cnt_q  [OUT_W];
    logic [CNT_W-1:0]       cnt_nx [OUT_W];
    logic [OUT_W*CNT_W-1:0] cnt_flat_nx;
    logic                   take;
    logic                   last_smp;
    logic                   prime_ld;
    logic                   acc_en;
    logic                   win_close;
    logic                   rpt_ack;

    // Ready is withheld while a report is pending and while reset is asserted.
    assign in_ready = rst_n & (state_q != S_REPORT);
    assign take     = in_valid & in_ready;
    assign last_smp = (smp_q == SMP_W'(WIN_LEN - 1));
    assign tog      = in_data ^ prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prime_ld  = 1'b0;
        acc_en    = 1'b0;
        win_close = 1'b0;
        rpt_ack   = 1'b0;
        case (state_q)
            S_PRIME: begin
                if (take) begin
                    prime_ld = 1'b1;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (take) begin
                    acc_en = 1'b1;
                    if (last_smp) begin
                        win_close = 1'b1;
                        state_d   = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (rpt_valid && rpt_ready) begin
                    rpt_ack = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            default: state_d = S_PRIME;
        endcase
    end

    // Saturating per-bit increment; the flat copy feeds the report register directly.
    always_comb begin
        cnt_nx      = cnt_q;
        cnt_flat_nx = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (tog[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_nx[i] = cnt_q[i] + CNT_W'(1);
            end
            cnt_flat_nx[i*CNT_W +: CNT_W] = cnt_nx[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            smp_q      <= '0;
            rpt_valid  <= 1'b0;
            rpt_cnt    <= '0;
            rpt_win_id <= '0;
            for (int i = 0; i < int'(OUT_W); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (prime_ld) begin
                prev_q <= in_data;
            end
            if (acc_en) begin
                prev_q <= in_data;
                smp_q  <= smp_q + SMP_W'(1);
                for (int i = 0; i < int'(OUT_W); i++) begin
                    cnt_q[i] <= cnt_nx[i];
                end
            end
            if (win_close) begin
                rpt_valid <= 1'b1;
                rpt_cnt   <= cnt_flat_nx;
            end
            // prev_q survives the report so boundary toggles land in the next window.
            if (rpt_ack) begin
                rpt_valid  <= 1'b0;
                smp_q      <= '0;
                rpt_win_id <= rpt_win_id + 8'd1;
                for (int i = 0; i < int'(OUT_W); i++) begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

`ifdef PLA_TOG_HAMMING_EN
    localparam int unsigned HAM_W  = CNT_W + 3;
    localparam int unsigned HSUM_W = HAM_W + 1;
    localparam int unsigned POP_W  = $clog2(OUT_W + 1);

    logic [HAM_W-1:0]  ham_q;
    logic [HAM_W-1:0]  ham_nx;
    logic [HSUM_W-1:0] ham_sum;
    logic [POP_W-1:0]  pop;

    // Popcount of this sample's toggles added into a saturating window total.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            pop = pop + POP_W'(tog[i]);
        end
        ham_sum = {1'b0, ham_q} + HSUM_W'(pop);
        ham_nx  = ham_sum[HAM_W] ? {HAM_W{1'b1}} : ham_sum[HAM_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ham_q   <= '0;
            rpt_ham <= '0;
        end else begin
            if (acc_en) begin
                ham_q <= ham_nx;
            end
            if (win_close) begin
                rpt_ham <= ham_nx;
            end
            if (rpt_ack) begin
                ham_q <= '0;
            end
        end
    end
`endif

endmodule
